// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU datapath constants and ALU control encodings
package cpu_pkg;

    localparam int REGISTER_LENGTH = 64;
    localparam int REG_ADDR_LENGTH = 5;
    localparam int NUM_REGISTERS   = 32;

    typedef logic [REGISTER_LENGTH-1:0] reg_data_t;
    typedef logic [REG_ADDR_LENGTH-1:0] reg_addr_t;

    // XZR: reads as zero, writes are discarded, has no storage
    localparam reg_addr_t ZERO_REG = 5'd31;

    typedef enum logic [2:0] {
        ALU_PASS_B   = 3'b000,
        ALU_ADD      = 3'b010,
        ALU_SUBTRACT = 3'b011,
        ALU_AND      = 3'b100,
        ALU_OR       = 3'b101,
        ALU_XOR      = 3'b110
    } alu_op_e;

endpackage

// File: rtl/register_word.sv
// rtl/register_word.sv - one register-file entry: enabled flop with async active-low clear
module register_word #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x64 integer register file with XZR and optional write-to-read bypass
module register_file
    import cpu_pkg::*;
#(
    parameter bit WRITE_BYPASS = 1'b1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  reg_addr_t ReadRegister1_i,
    input  reg_addr_t ReadRegister2_i,
    input  reg_addr_t WriteRegister_i,
    input  reg_data_t WriteData_i,
    input  logic      RegWrite_i,
    output reg_data_t ReadData1_o,
    output reg_data_t ReadData2_o
);

    reg_data_t words [NUM_REGISTERS];

    genvar i;
    generate
        for (i = 0; i < NUM_REGISTERS; i++) begin : g_reg
            if (i == int'(ZERO_REG)) begin : g_zero
                assign words[i] = '0;
            end else begin : g_word
                register_word #(
                    .WIDTH (REGISTER_LENGTH)
                ) u_word (
                    .clk_i  (clk_i),
                    .rst_ni (rst_ni),
                    .en_i   (RegWrite_i && (WriteRegister_i == reg_addr_t'(i))),
                    .d_i    (WriteData_i),
                    .q_o    (words[i])
                );
            end
        end
    endgenerate

    logic bypass1;
    logic bypass2;

    assign bypass1 = WRITE_BYPASS && RegWrite_i && (WriteRegister_i == ReadRegister1_i);
    assign bypass2 = WRITE_BYPASS && RegWrite_i && (WriteRegister_i == ReadRegister2_i);

    // Zero-register and reset gating override the bypass so XZR and a held reset always read 0
    always_comb begin
        ReadData1_o = words[ReadRegister1_i];
        if (bypass1) begin
            ReadData1_o = WriteData_i;
        end
        if (!rst_ni || (ReadRegister1_i == ZERO_REG)) begin
            ReadData1_o = '0;
        end
    end

    always_comb begin
        ReadData2_o = words[ReadRegister2_i];
        if (bypass2) begin
            ReadData2_o = WriteData_i;
        end
        if (!rst_ni || (ReadRegister2_i == ZERO_REG)) begin
            ReadData2_o = '0;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file, bypass and no-bypass builds
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa;
    logic [63:0] wd;
    logic        we;
    logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;

    int checks = 0;
    int failures = 0;
    logic [63:0] model [32];

    always #5 clk = ~clk;

    register_file #(.WRITE_BYPASS(1'b1)) dut_byp (
        .clk_i(clk), .rst_ni(rst_n),
        .ReadRegister1_i(ra1), .ReadRegister2_i(ra2),
        .WriteRegister_i(wa), .WriteData_i(wd), .RegWrite_i(we),
        .ReadData1_o(rd1_b), .ReadData2_o(rd2_b)
    );

    register_file #(.WRITE_BYPASS(1'b0)) dut_nob (
        .clk_i(clk), .rst_ni(rst_n),
        .ReadRegister1_i(ra1), .ReadRegister2_i(ra2),
        .WriteRegister_i(wa), .WriteData_i(wd), .RegWrite_i(we),
        .ReadData1_o(rd1_n), .ReadData2_o(rd2_n)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] expect_read(input logic [4:0] ra, input bit bypass);
        if (!rst_n || ra == 5'd31) return 64'h0;
        if (bypass && we && wa == ra) return wd;
        return model[ra];
    endfunction

    task automatic check_reads(input string tag);
        #1;
        check({tag, "_b1"}, rd1_b, expect_read(ra1, 1'b1));
        check({tag, "_b2"}, rd2_b, expect_read(ra2, 1'b1));
        check({tag, "_n1"}, rd1_n, expect_read(ra1, 1'b0));
        check({tag, "_n2"}, rd2_n, expect_read(ra2, 1'b0));
    endtask

    task automatic clear_model();
        for (int k = 0; k < 32; k++) model[k] = 64'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) clear_model();
        else if (we && wa != 5'd31) model[wa] = wd;
        #2;
    endtask

    task automatic drive(input logic w, input logic [4:0] a, input logic [63:0] d,
                         input logic [4:0] r1, input logic [4:0] r2);
        we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
    endtask

    task automatic sweep(input string tag);
        we = 1'b0;
        for (int k = 0; k < 32; k++) begin
            ra1 = 5'(k);
            ra2 = 5'(31 - k);
            check_reads(tag);
        end
    endtask

    initial begin
        clear_model();
        rst_n = 1'b0;
        drive(1'b1, 5'd5, 64'hCAFE, 5'd5, 5'd5);
        tick();
        check_reads("reset_bypass_gated");
        tick();
        rst_n = 1'b1;
        sweep("reset_read_all");

        // Write X5 then X30 on successive edges
        drive(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd30);
        #1;
        check("wr_x5", rd1_b, 64'hDEAD_BEEF_0123_4567);
        check("wr_x30", rd2_b, 64'hFFFF_FFFF_FFFF_FFFF);
        sweep("after_write");

        // Write to XZR is discarded on both sides of the edge
        drive(1'b1, 5'd31, 64'h1234, 5'd31, 5'd31);
        #1;
        check("xzr_pre1", rd1_b, 64'h0);
        check("xzr_pre2", rd2_b, 64'h0);
        tick();
        #1;
        check("xzr_post1", rd1_b, 64'h0);
        check("xzr_post2", rd2_n, 64'h0);
        sweep("after_xzr");

        // Bypass: X7 holds 0x10, same-cycle write of 0x20
        drive(1'b1, 5'd7, 64'h10, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd7, 64'h20, 5'd7, 5'd7);
        #1;
        check("byp_pre1", rd1_b, 64'h20);
        check("byp_pre2", rd2_b, 64'h20);
        check("nob_pre1", rd1_n, 64'h10);
        check("nob_pre2", rd2_n, 64'h10);
        tick();
        we = 1'b0;
        #1;
        check("nob_post1", rd1_n, 64'h20);
        check("byp_post2", rd2_b, 64'h20);

        // Write disable leaves X3 unchanged
        drive(1'b1, 5'd3, 64'h55, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd3, 64'hAAAA, 5'd3, 5'd3);
        tick();
        #1;
        check("wdis_b", rd1_b, 64'h55);
        check("wdis_n", rd2_n, 64'h55);

        // Async reset between edges wins over a concurrent write to X9
        drive(1'b1, 5'd9, 64'h77, 5'd9, 5'd9);
        tick();
        #1;
        drive(1'b1, 5'd9, 64'h99, 5'd9, 5'd9);
        rst_n = 1'b0;
        clear_model();
        #1;
        check("arst_now_b", rd1_b, 64'h0);
        check("arst_now_n", rd2_n, 64'h0);
        tick();
        we = 1'b0;
        rst_n = 1'b1;
        #1;
        check("arst_after_b", rd1_b, 64'h0);
        check("arst_after_n", rd1_n, 64'h0);
        sweep("after_arst");

        // Randomized traffic, biased toward read/write index collisions
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  {$urandom, $urandom}, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) wa = ra1;
            if ($urandom_range(0, 3) == 0) ra2 = wa;
            check_reads("rand");
            tick();
        end
        sweep("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 64-bit integer register file.
- Sits directly upstream of the ALU: read port A drives ALU A_i, and read port B drives the ALU B-operand mux (ahead of immediate selection).
- The write port is fed by the writeback stage, i.e. ALU Result_o or load data.
- Register 31 is the hardwired zero register (XZR).

Parameters:
- REGISTER_LENGTH, 64, data width of every register and port; matches the ALU.
- REG_ADDR_LENGTH, 5, register index width.
- NUM_REGISTERS, 32, entry count; must equal 2**REG_ADDR_LENGTH.
- ZERO_REG, 31, index of the hardwired zero register.
- WRITE_BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = reads return pre-write contents.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- ReadRegister1_i  input  REG_ADDR_LENGTH  read port A index.
- ReadRegister2_i  input  REG_ADDR_LENGTH  read port B index.
- WriteRegister_i  input  REG_ADDR_LENGTH  write index.
- WriteData_i  input  REGISTER_LENGTH  write data.
- RegWrite_i  input  1  write enable.
- ReadData1_o  output  REGISTER_LENGTH  read port A data (to ALU A_i).
- ReadData2_o  output  REGISTER_LENGTH  read port B data (to ALU B path / store data).

Behaviour:
- Reset:
  - rst_ni low asynchronously clears all 31 storage registers to 0, regardless of clk_i.
  - While rst_ni is low, ReadData1_o and ReadData2_o are 0 and writes are ignored.
  - On reset release, the first rising edge with rst_ni high may write.
- Storage:
  - Only indices 0..30 have flops; there is no storage for ZERO_REG.
- Write:
  - At a rising edge with RegWrite_i=1 and WriteRegister_i != ZERO_REG, reg[WriteRegister_i] <= WriteData_i.
  - Writes to ZERO_REG are silently discarded.
  - RegWrite_i=0 leaves all registers unchanged.
  - Write latency is 1 cycle; the new value is visible at the storage outputs after the edge.
- Read:
  - Both ports are combinational and fully independent; both may address the same register.
  - Index ZERO_REG always returns 0, including when a write to 31 is pending.
- Bypass (WRITE_BYPASS=1):
  - If RegWrite_i=1, WriteRegister_i == ReadRegisterN_i and the index != ZERO_REG, then ReadDataN_o = WriteData_i in the same cycle. This is write-first semantics.
  - Applies to each port independently and to both ports simultaneously.
- WRITE_BYPASS=0:
  - The port returns the stored value until the edge, and the new value afterwards.
- Simultaneous events:
  - A reset assertion during a write cycle wins: the register is 0 after the edge.
  - Writing the same index on consecutive cycles gives last-writer-wins.
- Arithmetic/width rules:
  - None; data passes unmodified.
  - No X propagation on reads of never-written registers: they read 0 after reset.

Decomposition:
- Shared package cpu_pkg: REGISTER_LENGTH, REG_ADDR_LENGTH, NUM_REGISTERS, ZERO_REG (XZR = 5'd31). The ALU control encodings (ALU_PASS_B=3'b000, ALU_ADD=3'b010, ALU_SUBTRACT=3'b011, ALU_AND=3'b100, ALU_OR=3'b101, ALU_XOR=3'b110) also move there so decoder and ALU share them.
- One sub-module, register_word:
  - One REGISTER_LENGTH-bit flop with enable and asynchronous active-low clear.
  - Generated for indices 0..ZERO_REG-1, with enable = RegWrite_i & (WriteRegister_i == index) (one-hot decode).
- Read muxes and bypass logic live in register_file.

Test Plan:
- Reset then read all: rst_ni=0 for 2 cycles, release, sweep ReadRegister1_i/2_i over 0..31 -> every read = 64'h0.
- Write/readback:
  - Write X5=64'hDEAD_BEEF_0123_4567 and X30=64'hFFFF_FFFF_FFFF_FFFF on successive edges.
  - Read Rn1=5, Rn2=30 -> ReadData1_o=64'hDEAD_BEEF_0123_4567, ReadData2_o=64'hFFFF_FFFF_FFFF_FFFF.
  - All other indices remain 0.
- Zero register:
  - Write X31=64'h1234 with RegWrite_i=1 and hold it, reading Rn1=Rn2=31 in that cycle and after the edge -> both ports 0 at all times.
  - No other register changes.
- Bypass:
  - X7 holds 64'h10; same cycle set RegWrite_i=1, WriteRegister_i=7, WriteData_i=64'h20, Rn1=7, Rn2=7.
  - WRITE_BYPASS=1 -> both ports 64'h20 before the edge.
  - WRITE_BYPASS=0 -> 64'h10 before the edge, 64'h20 after.
- Write disable: RegWrite_i=0, WriteRegister_i=3, WriteData_i=64'hAAAA -> X3 unchanged (previous 64'h55 still read).
- Async reset mid-operation:
  - X9=64'h77; assert rst_ni low between clock edges, concurrent with RegWrite_i=1 to X9 with data 64'h99.
  - Read X9 immediately (no edge) -> 0; it stays 0 after release until rewritten.
